// File: rtl/emu_csr_sequencer_if.sv
// AXI-lite bus between the CSR sequencer (master) and the emulator
// control slave port.
//   master modport: drives AW/W/AR valids, addresses, data, strobes, prot
//                   and B/R readys
//   slave modport : drives AW/W/AR readys, B/R valids, response codes and
//                   read data
interface emu_csr_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  // write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  // write data channel
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  // write response channel
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  // read address channel
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  // read data channel
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/emu_csr_sequencer.sv
// CSR command sequencer: executes WRITE / READ / POLL commands as AXI-lite
// master transactions against the emulator control port, returning exactly
// one response (read data + status) per command, strictly in order.
//   clk, resetn        : clock, asynchronous active-low reset
//   cmd_*              : command stream (valid/ready), op/addr/wdata/expect
//   rsp_*              : response stream (valid/ready), rdata/status
//   m_axilite          : AXI-lite master port (emu_csr_sequencer_if.master)
module emu_csr_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned POLL_INTERVAL  = 20,
  parameter int unsigned POLL_MAX_TRIES = 0,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [31:0]           cmd_expect,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_status,
  emu_csr_sequencer_if.master   m_axilite
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_AXI_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  // last count value of the inter-poll wait (guarded for a zero interval)
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST =
    (POLL_INTERVAL == 0) ? '0 : CNT_WIDTH'(POLL_INTERVAL - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_TRIES = CNT_WIDTH'(POLL_MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_POLL_WAIT, S_RSP
  } state_e;

  state_e                state_q,      state_d;
  logic [1:0]            op_q,         op_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [31:0]           wdata_q,      wdata_d;
  logic [31:0]           expect_q,     expect_d;
  logic [CNT_WIDTH-1:0]  tries_q,      tries_d;
  logic [CNT_WIDTH-1:0]  wait_q,       wait_d;
  logic                  cmd_ready_q,  cmd_ready_d;
  logic                  awvalid_q,    awvalid_d;
  logic                  wvalid_q,     wvalid_d;
  logic                  bready_q,     bready_d;
  logic                  arvalid_q,    arvalid_d;
  logic                  rready_q,     rready_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [31:0]           rsp_rdata_q,  rsp_rdata_d;
  logic [1:0]            rsp_status_q, rsp_status_d;

  logic                  aw_done, w_done;
  logic [CNT_WIDTH-1:0]  tries_inc;
  logic                  poll_match;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    expect_d     = expect_q;
    tries_d      = tries_q;
    wait_d       = wait_q;
    cmd_ready_d  = cmd_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    // a channel is complete once its valid has dropped or handshakes now
    aw_done    = !awvalid_q || m_axilite.awready;
    w_done     = !wvalid_q  || m_axilite.wready;
    tries_inc  = (tries_q == '1) ? tries_q : tries_q + CNT_WIDTH'(1);
    poll_match = (m_axilite.rdata & wdata_q) == expect_q;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          expect_d    = cmd_expect;
          tries_d     = '0;
          cmd_ready_d = 1'b0;
          if (cmd_op == OP_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else if (cmd_op == OP_READ || cmd_op == OP_POLL) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = ST_ILLEGAL;
            state_d      = S_RSP;
          end
        end
      end

      S_WR_REQ: begin
        if (awvalid_q && m_axilite.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axilite.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axilite.bvalid) begin
          bready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_status_d = (m_axilite.bresp != 2'd0) ? ST_AXI_ERR : ST_OK;
          state_d      = S_RSP;
        end
      end

      S_RD_REQ: begin
        if (m_axilite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axilite.rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axilite.rdata;
          if (op_q != OP_POLL) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = (m_axilite.rresp != 2'd0) ? ST_AXI_ERR : ST_OK;
            state_d      = S_RSP;
          end else begin
            tries_d = tries_inc;
            if (m_axilite.rresp != 2'd0) begin
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_AXI_ERR;
              state_d      = S_RSP;
            end else if (poll_match) begin
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_OK;
              state_d      = S_RSP;
            end else if (MAX_TRIES != '0 && tries_inc == MAX_TRIES) begin
              rsp_valid_d  = 1'b1;
              rsp_status_d = ST_TIMEOUT;
              state_d      = S_RSP;
            end else if (POLL_INTERVAL == 0) begin
              arvalid_d = 1'b1;
              state_d   = S_RD_REQ;
            end else begin
              wait_d  = '0;
              state_d = S_POLL_WAIT;
            end
          end
        end
      end

      // exactly POLL_INTERVAL idle cycles before the next poll read
      S_POLL_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          arvalid_d = 1'b1;
          state_d   = S_RD_REQ;
        end else begin
          wait_d = wait_q + CNT_WIDTH'(1);
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      expect_q     <= '0;
      tries_q      <= '0;
      wait_q       <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      expect_q     <= expect_d;
      tries_q      <= tries_d;
      wait_q       <= wait_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;

  assign m_axilite.awvalid = awvalid_q;
  assign m_axilite.awaddr  = addr_q;
  assign m_axilite.awprot  = 3'b000;
  assign m_axilite.wvalid  = wvalid_q;
  assign m_axilite.wdata   = wdata_q;
  assign m_axilite.wstrb   = 4'hF;
  assign m_axilite.bready  = bready_q;
  assign m_axilite.arvalid = arvalid_q;
  assign m_axilite.araddr  = addr_q;
  assign m_axilite.arprot  = 3'b000;
  assign m_axilite.rready  = rready_q;

endmodule

// File: tb/tb_emu_csr_sequencer.sv
// Directed bench for emu_csr_sequencer with a small AXI-lite slave model.
module tb_emu_csr_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_expect;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  always #5 clk = ~clk;

  emu_csr_sequencer_if #(.ADDR_WIDTH(12)) ax ();

  emu_csr_sequencer #(
    .ADDR_WIDTH(12), .POLL_INTERVAL(20), .POLL_MAX_TRIES(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_expect(cmd_expect),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .m_axilite(ax.master)
  );

  // ---------------- slave model + monitors ----------------
  logic [3:0]  aw_delay, w_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] rd_mem [64];
  logic [5:0]  rd_idx;
  logic [3:0]  aw_cnt, w_cnt;
  logic        aw_got, w_got;
  int          aw_total, w_total, b_total, ar_total;
  logic [11:0] aw_addr_seen, ar_addr_seen;
  logic [31:0] w_data_seen;
  logic [3:0]  w_strb_seen;
  logic [2:0]  aw_prot_seen;
  int          aw_hi, w_hi, aw_unstable;
  logic        prev_awvalid;
  logic [11:0] prev_awaddr;
  logic        in_gap;
  int          gap_cnt, gap_n;
  int          gaps [32];

  logic aw_hs, w_hs, ar_hs, r_hs, b_hs, acc_hs;
  assign aw_hs  = ax.awvalid && ax.awready;
  assign w_hs   = ax.wvalid && ax.wready;
  assign ar_hs  = ax.arvalid && ax.arready;
  assign r_hs   = ax.rvalid && ax.rready;
  assign b_hs   = ax.bvalid && ax.bready;
  assign acc_hs = cmd_valid && cmd_ready;

  always_comb begin
    ax.awready = ax.awvalid && (aw_cnt >= aw_delay);
    ax.wready  = ax.wvalid && (w_cnt >= w_delay);
    ax.arready = ax.arvalid;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt <= '0; w_cnt <= '0; aw_got <= 1'b0; w_got <= 1'b0;
      ax.bvalid <= 1'b0; ax.bresp <= 2'd0;
      ax.rvalid <= 1'b0; ax.rresp <= 2'd0; ax.rdata <= '0;
      rd_idx <= '0;
      aw_total <= 0; w_total <= 0; b_total <= 0; ar_total <= 0;
      aw_addr_seen <= '0; ar_addr_seen <= '0; w_data_seen <= '0;
      w_strb_seen <= '0; aw_prot_seen <= '0;
      aw_hi <= 0; w_hi <= 0; aw_unstable <= 0;
      prev_awvalid <= 1'b0; prev_awaddr <= '0;
      in_gap <= 1'b0; gap_cnt <= 0; gap_n <= 0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= '0; aw_total <= aw_total + 1;
        aw_addr_seen <= ax.awaddr; aw_prot_seen <= ax.awprot;
      end else if (ax.awvalid) aw_cnt <= aw_cnt + 4'd1;
      if (w_hs) begin
        w_cnt <= '0; w_total <= w_total + 1;
        w_data_seen <= ax.wdata; w_strb_seen <= ax.wstrb;
      end else if (ax.wvalid) w_cnt <= w_cnt + 4'd1;
      if (b_hs) begin
        ax.bvalid <= 1'b0; b_total <= b_total + 1;
      end
      // B issued the cycle after the later of the AW/W handshakes
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        ax.bvalid <= 1'b1; ax.bresp <= cfg_bresp;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (ar_hs) begin
        ax.rvalid <= 1'b1; ax.rdata <= rd_mem[rd_idx]; ax.rresp <= cfg_rresp;
        rd_idx <= rd_idx + 6'd1; ar_total <= ar_total + 1;
        ar_addr_seen <= ax.araddr;
      end else if (r_hs) ax.rvalid <= 1'b0;
      // per-command valid-high cycle counts and AW address stability
      if (acc_hs) begin
        aw_hi <= 0; w_hi <= 0;
      end else begin
        if (ax.awvalid) aw_hi <= aw_hi + 1;
        if (ax.wvalid)  w_hi  <= w_hi + 1;
      end
      if (ax.awvalid && prev_awvalid && ax.awaddr != prev_awaddr)
        aw_unstable <= aw_unstable + 1;
      prev_awvalid <= ax.awvalid; prev_awaddr <= ax.awaddr;
      // idle cycles between an R handshake and the next AR request
      if (acc_hs) in_gap <= 1'b0;
      else if (r_hs) begin
        in_gap <= 1'b1; gap_cnt <= 0;
      end else if (in_gap) begin
        if (ax.arvalid) begin
          in_gap <= 1'b0; gaps[gap_n[4:0]] <= gap_cnt; gap_n <= gap_n + 1;
        end else if (!ax.rready) gap_cnt <= gap_cnt + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [31:0] ex);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_wdata = wd; cmd_expect = ex;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    // garbage on the command bus: captured fields must not be resampled
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_addr = 12'hFFF;
    cmd_wdata = 32'hFFFF_FFFF; cmd_expect = 32'hA5A5_A5A5;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  // call right after send(); latency counts the accept cycle as cycle 0
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] st,
                          output int lat);
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_wait", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    st = rsp_status;
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic [1:0]  st;
  int          lat, base_aw, base_w, base_b, base_ar, base_gap, base_unst;
  int          idx;

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0;
    cmd_wdata = '0; cmd_expect = '0; rsp_ready = 1'b0;
    aw_delay = 4'd0; w_delay = 4'd0; cfg_bresp = 2'd0; cfg_rresp = 2'd0;
    for (int i = 0; i < 64; i++) rd_mem[i] = '0;
    #12;
    check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_rdata",  rsp_rdata,       32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_awvalid",    32'(ax.awvalid), 32'd0);
    check("rst_arvalid",    32'(ax.arvalid), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 1: simple WRITE, immediate slave
    base_aw = aw_total; base_w = w_total; base_b = b_total;
    send(2'd0, 12'h010, 32'h3, 32'h0);
    wait_rsp(rd, st, lat);
    check("wr_latency",  32'(lat), 32'd3);
    check("wr_status",   32'(st),  32'd0);
    check("wr_rdata",    rd,       32'd0);
    check("wr_aw_count", 32'(aw_total - base_aw), 32'd1);
    check("wr_w_count",  32'(w_total - base_w),   32'd1);
    check("wr_b_count",  32'(b_total - base_b),   32'd1);
    check("wr_awaddr",   32'(aw_addr_seen), 32'h010);
    check("wr_awprot",   32'(aw_prot_seen), 32'd0);
    check("wr_wdata",    w_data_seen,       32'h3);
    check("wr_wstrb",    32'(w_strb_seen),  32'hF);
    consume();

    // 2: WRITE with awready delayed 4 cycles
    aw_delay = 4'd4;
    base_b = b_total; base_unst = aw_unstable;
    send(2'd0, 12'h014, 32'h5, 32'h0);
    wait_rsp(rd, st, lat);
    check("wrd_aw_cycles", 32'(aw_hi), 32'd5);
    check("wrd_w_cycles",  32'(w_hi),  32'd1);
    check("wrd_aw_stable", 32'(aw_unstable - base_unst), 32'd0);
    check("wrd_awaddr",    32'(aw_addr_seen), 32'h014);
    check("wrd_wdata",     w_data_seen, 32'h5);
    check("wrd_b_count",   32'(b_total - base_b), 32'd1);
    check("wrd_status",    32'(st), 32'd0);
    consume();
    aw_delay = 4'd0;

    // 3: READ with rsp_ready held low for 3 cycles
    rd_mem[rd_idx] = 32'h1234_5678;
    send(2'd1, 12'h020, 32'h0, 32'h0);
    wait_rsp(rd, st, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata",   rd, 32'h1234_5678);
    check("rd_status",  32'(st), 32'd0);
    check("rd_araddr",  32'(ar_addr_seen), 32'h020);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rd_hold_valid", 32'(rsp_valid), 32'd1);
      check("rd_hold_rdata", rsp_rdata, 32'h1234_5678);
      check("rd_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    consume();

    // 4: POLL mask=1 expect=1, slave returns 0,0,1
    idx = int'(rd_idx);
    rd_mem[6'(idx)] = 32'h0; rd_mem[6'(idx + 1)] = 32'h0;
    rd_mem[6'(idx + 2)] = 32'h1;
    base_ar = ar_total; base_gap = gap_n;
    send(2'd2, 12'h030, 32'h1, 32'h1);
    wait_rsp(rd, st, lat);
    check("poll_reads",  32'(ar_total - base_ar), 32'd3);
    check("poll_ngaps",  32'(gap_n - base_gap),   32'd2);
    check("poll_gap0",   32'(gaps[base_gap % 32]),       32'd20);
    check("poll_gap1",   32'(gaps[(base_gap + 1) % 32]), 32'd20);
    check("poll_status", 32'(st), 32'd0);
    check("poll_rdata",  rd, 32'h1);
    consume();

    // 5: POLL never matching -> timeout after 4 reads, last rdata returned
    idx = int'(rd_idx);
    for (int k = 0; k < 6; k++) rd_mem[6'(idx + k)] = 32'(16 * (k + 1));
    base_ar = ar_total;
    send(2'd2, 12'h034, 32'h1, 32'h1);
    wait_rsp(rd, st, lat);
    check("pto_reads",  32'(ar_total - base_ar), 32'd4);
    check("pto_status", 32'(st), 32'd2);
    check("pto_rdata",  rd, 32'h40);
    consume();

    // 6: illegal op -> no AXI traffic, status 3
    base_ar = ar_total; base_aw = aw_total;
    send(2'd3, 12'h040, 32'h77, 32'h0);
    wait_rsp(rd, st, lat);
    check("ill_status", 32'(st), 32'd3);
    check("ill_rdata",  rd, 32'd0);
    check("ill_no_ar",  32'(ar_total - base_ar), 32'd0);
    check("ill_no_aw",  32'(aw_total - base_aw), 32'd0);
    consume();

    // 7: READ with rresp=2 -> status 1
    cfg_rresp = 2'd2;
    rd_mem[rd_idx] = 32'hCAFE_F00D;
    send(2'd1, 12'h044, 32'h0, 32'h0);
    wait_rsp(rd, st, lat);
    check("rderr_status", 32'(st), 32'd1);
    check("rderr_rdata",  rd, 32'hCAFE_F00D);
    consume();
    cfg_rresp = 2'd0;

    // 8: async reset while awvalid is pending, then a clean READ
    aw_delay = 4'd10;
    send(2'd0, 12'h050, 32'h9, 32'h0);
    @(posedge clk); @(posedge clk); #3;
    check("rst_pre_awvalid", 32'(ax.awvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("arst_awvalid",    32'(ax.awvalid),  32'd0);
    check("arst_wvalid",     32'(ax.wvalid),   32'd0);
    check("arst_bready",     32'(ax.bready),   32'd0);
    check("arst_arvalid",    32'(ax.arvalid),  32'd0);
    check("arst_rready",     32'(ax.rready),   32'd0);
    check("arst_cmd_ready",  32'(cmd_ready),   32'd0);
    check("arst_rsp_valid",  32'(rsp_valid),   32'd0);
    check("arst_rsp_rdata",  rsp_rdata,        32'd0);
    check("arst_rsp_status", 32'(rsp_status),  32'd0);
    @(negedge clk);
    resetn = 1'b1;
    aw_delay = 4'd0;
    rd_mem[rd_idx] = 32'h5A5A_0001;
    send(2'd1, 12'h060, 32'h0, 32'h0);
    wait_rsp(rd, st, lat);
    check("post_rst_rdata",  rd, 32'h5A5A_0001);
    check("post_rst_status", 32'(st), 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/emu_csr_sequencer.md
Name: emu_csr_sequencer

Overview:
AXI-lite master that executes a stream of CSR commands (write, read, poll-until-match) against the emulator control slave port (s_axilite_* of emu_system). It sits directly upstream of that port and replaces hand-sequenced host transactions such as:
- setting the step count;
- start/halt via the STAT register;
- waiting for the trigger bit;
- polling DMA_STAT until idle.

Each command produces exactly one response carrying read data and a status code.

Parameters:
ADDR_WIDTH, 12, CSR byte address width; matches s_axilite_awaddr/araddr.
POLL_INTERVAL, 20, idle cycles between poll reads after a mismatch; 0 means back-to-back.
POLL_MAX_TRIES, 0, maximum poll reads before timeout; 0 means unlimited.
CNT_WIDTH, 16, width of the interval and tries counters; must be able to hold both POLL_INTERVAL and POLL_MAX_TRIES.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved
cmd_addr  in  ADDR_WIDTH  CSR address
cmd_wdata  in  32  WRITE data; POLL mask
cmd_expect  in  32  POLL expected value after masking
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready
rsp_rdata  out  32  read data (READ, POLL); 0 for WRITE
rsp_status  out  2  0=OK, 1=AXI error (resp!=0), 2=poll timeout, 3=illegal op
m_axilite_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
m_axilite_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data channel
m_axilite_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
m_axilite_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
m_axilite_rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data channel

Behaviour:
- Reset values: all valids and readys 0; rsp_rdata 0; rsp_status 0; state IDLE.
- cmd_ready=1 only in IDLE.
- Interface constants: awprot=arprot=0; wstrb=4'hF.
- Command capture: on accept, op, addr, wdata/mask and expect are registered. The command fields must not be sampled again.
- WRITE path, state WR_REQ:
  - awvalid and wvalid assert together on the cycle after accept.
  - Each drops independently on its own handshake; AW and W may complete in either order or the same cycle.
  - Once both have completed, go to WR_RESP with bready=1.
  - On bvalid: status = (bresp!=0)?1:0; go to RSP.
- READ path, state RD_REQ:
  - arvalid=1 until arready.
  - Then RD_DATA with rready=1.
  - On rvalid: capture rdata; status = (rresp!=0)?1:0; go to RSP.
- POLL path:
  - Performs the RD_REQ/RD_DATA read and increments the tries counter.
  - rresp!=0: status 1, go to RSP immediately.
  - Match, i.e. (rdata & mask)==expect: status 0, go to RSP.
  - Mismatch with POLL_MAX_TRIES!=0 and tries==POLL_MAX_TRIES: status 2 with last rdata, go to RSP.
  - Mismatch otherwise: go to POLL_WAIT. Count POLL_INTERVAL cycles, then RD_REQ again (direct to RD_REQ if POLL_INTERVAL=0).
- Illegal op (3): no AXI traffic; go to RSP with status 3 and rdata 0.
- RSP state:
  - rsp_valid=1 with stable rdata and status until rsp_ready.
  - Then IDLE; a new command may be accepted the next cycle.
- Ordering: one outstanding command only; responses are returned strictly in command order.
- Minimum latency (slave ready same cycle, response next cycle):
  - WRITE: accept→rsp_valid = 3 cycles.
  - READ: accept→rsp_valid = 3 cycles.
- Valid stability: no valid is deasserted without its handshake.
- Reset mid-transaction: asynchronous return to the reset values; any in-flight AXI transaction is abandoned. The slave is reset on the same resetn.
- Counters: the tries counter saturates and never wraps.

Test Plan:
- WRITE addr 0x010 data 0x3, slave ready immediately, bresp=0 -> one AW+W beat with wdata=0x3, wstrb=F; rsp_status 0, rsp_rdata 0, rsp_valid 3 cycles after accept.
- WRITE with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles with stable awaddr; exactly one B accepted; status 0.
- READ addr 0x020, rdata=0x1234_5678, rresp=0; rsp_ready low for 3 cycles -> rsp_valid held with rdata 0x12345678 until ready; cmd_ready 0 throughout.
- POLL mask=1 expect=1; slave returns 0,0,1 -> 3 AR transactions spaced by POLL_INTERVAL=20 idle cycles; status 0, rdata=1.
- POLL with POLL_MAX_TRIES=4; slave always returns 0 -> exactly 4 reads, status 2, rdata 0. Separately, READ with rresp=2 -> status 1.
- resetn pulsed low while awvalid is pending -> all outputs 0 asynchronously; after release, a new READ completes normally with status 0.
